// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   state_e       : operation state (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width
//   cnt_w()       : width of the bit counter needed for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/busy/done handshake plus operand and result bus of the
// bit-serial subtractor.
//   master : sequencer side (drives start, a, b, bin; observes results)
//   slave  : subtractor side
// When SERIAL_SUB_SIGNED_OVF_EN is defined the bus also carries ovf, the
// two's-complement overflow flag of the result.
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             borrow;
    logic             zero;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin,
                    input  busy, done, y, borrow, zero, ovf);
    modport slave  (input  start, a, b, bin,
                    output busy, done, y, borrow, zero, ovf);
`else
    modport master (output start, a, b, bin,
                    input  busy, done, y, borrow, zero);
    modport slave  (input  start, a, b, bin,
                    output busy, done, y, borrow, zero);
`endif
endinterface

// File: rtl/serial_sub_full_sub.sv
// full_sub: combinational 1-bit full subtractor, d = x - y - bin.
//   x, y : minuend and subtrahend bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when they are equal and a borrow arrives.
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, y = a - b - bin, one bit per clock,
// LSB first. Operands are latched on an accepted start; results y, borrow
// and zero (and ovf when SERIAL_SUB_SIGNED_OVF_EN is defined) are registered
// when the operation completes and hold until the next completion.
// Ports:
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : serial_sub_if.slave (start/a/b/bin in, busy/done/y/borrow/zero out)
// Handshake outputs are registered from the state, so busy is high for the
// WIDTH cycles following acceptance and done pulses WIDTH+1 cycles after it.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               br_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   y_r;
    logic               borrow_r;
    logic               zero_r;
    logic               accept_s;
    logic               last_s;
    logic               d_s;
    logic               bout_s;

    // A start is honoured only when no bits are being computed.
    assign accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

    full_sub u_full_sub (
        .x    (a_r[cnt_r]),
        .y    (b_r[cnt_r]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                // Back-to-back operation when start is still present.
                if (bus.start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand latch, running borrow, bit counter and result shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            br_r  <= 1'b0;
            cnt_r <= '0;
        end else if (accept_s) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            res_r <= '0;
            br_r  <= bus.bin;
            cnt_r <= '0;
        end else if (state_r == SHIFT) begin
            // Difference bits enter at the MSB so bit 0 lands at position 0.
            res_r <= {d_s, res_r[WIDTH-1:1]};
            br_r  <= bout_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            res_r <= res_r;
            br_r  <= br_r;
            cnt_r <= cnt_r;
        end
    end

    // Handshake flags and result registers; results only move in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            y_r      <= '0;
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            busy_r <= (state_r == SHIFT);
            done_r <= (state_r == DONE);
            if (state_r == DONE) begin
                y_r      <= res_r;
                borrow_r <= br_r;
                zero_r   <= (res_r == '0);
            end else begin
                y_r      <= y_r;
                borrow_r <= borrow_r;
                zero_r   <= zero_r;
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_r;

    // Two's-complement overflow: operand signs differ and the result sign
    // departs from the minuend sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state_r == DONE) begin
            ovf_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                     (res_r[WIDTH-1] != a_r[WIDTH-1]);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.y      = y_r;
    assign bus.borrow = borrow_r;
    assign bus.zero   = zero_r;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub (WIDTH=4).
// Covers reset state, several subtractions, latency and busy length, result
// hold during SHIFT, start ignored while busy, back-to-back operation,
// asynchronous reset mid-operation and, when SERIAL_SUB_SIGNED_OVF_EN is
// defined, the overflow flag.
module tb_serial_sub;
    import serial_sub_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    serial_sub_if #(.WIDTH(4)) bus ();

    serial_sub #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait up to 12 cycles for done; returns 0 on timeout.
    task automatic wait_done(output int lat, output int busy_n, output logic hold_ok,
                             input logic [3:0] y_prev);
        lat     = 0;
        busy_n  = 0;
        hold_ok = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.y !== y_prev) hold_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                          input logic ibin, input logic [3:0] ey, input logic eb,
                          input logic ez);
        int         lat;
        int         busy_n;
        logic       hold_ok;
        logic [3:0] y_prev;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.bin   = ibin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        y_prev    = bus.y;
        wait_done(lat, busy_n, hold_ok, y_prev);
        chk({tag, "_lat"},    32'(lat),     32'd5);
        chk({tag, "_busy"},   32'(busy_n),  32'd4);
        chk({tag, "_hold"},   32'(hold_ok), 32'd1);
        chk({tag, "_y"},      32'(bus.y),   32'(ey));
        chk({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
        chk({tag, "_zero"},   32'(bus.zero),   32'(ez));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   lat;
        int   busy_n;
        int   done_n;
        logic hold_ok;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_y",      32'(bus.y),      32'd0);
        chk("rst_borrow", 32'(bus.borrow), 32'd0);
        chk("rst_zero",   32'(bus.zero),   32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("rst_ovf",    32'(bus.ovf),    32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("sub9_3",  4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b0);
        run_op("sub3_9",  4'd3, 4'd9, 1'b0, 4'hA,  1'b1, 1'b0);
        run_op("sub5_5",  4'd5, 4'd5, 1'b0, 4'd0,  1'b0, 1'b1);
        run_op("sub0_0b", 4'd0, 4'd0, 1'b1, 4'hF,  1'b1, 1'b0);
        run_op("subF_Fb", 4'hF, 4'hF, 1'b1, 4'hF,  1'b1, 1'b0);
        run_op("subC_4b", 4'hC, 4'd4, 1'b1, 4'd7,  1'b0, 1'b0);

        // Start and new operands during SHIFT are ignored; start held through
        // DONE launches the second operation with the operands then present.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd3;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.a = 4'd1;
        bus.b = 4'd1;
        wait_done(lat, busy_n, hold_ok, 4'd7);
        chk("ign_lat",  32'(lat + 1),   32'd5);
        chk("ign_y",    32'(bus.y),     32'd6);
        chk("ign_zero", 32'(bus.zero),  32'd0);
        bus.start = 1'b0;
        wait_done(lat, busy_n, hold_ok, 4'd6);
        chk("b2b_lat",  32'(lat),       32'd5);
        chk("b2b_busy", 32'(busy_n),    32'd4);
        chk("b2b_y",    32'(bus.y),     32'd0);
        chk("b2b_zero", 32'(bus.zero),  32'd1);

        // Asynchronous reset in the second SHIFT cycle.
        run_op("pre_rst", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy",   32'(bus.busy),   32'd0);
        chk("arst_done",   32'(bus.done),   32'd0);
        chk("arst_y",      32'(bus.y),      32'd0);
        chk("arst_borrow", 32'(bus.borrow), 32'd0);
        chk("arst_zero",   32'(bus.zero),   32'd0);
        @(negedge clk);
        rst    = 1'b0;
        done_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_n++;
        end
        chk("arst_no_done", 32'(done_n), 32'd0);
        run_op("post_rst", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
        run_op("ovf8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0);
        chk("ovf8_1_ovf", 32'(bus.ovf), 32'd1);
        run_op("ovf7_1", 4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
        chk("ovf7_1_ovf", 32'(bus.ovf), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
